// File: rtl/riscv_run_ctrl.sv
// Run controller for the pipelined RISC-V core.
// Streams a program into instruction memory, holds the core in reset for a
// fixed number of cycles, then runs it until a store to TOHOST_ADDR or until
// the cycle watchdog expires.
// Ports:
//   clk, rst (sync, active-low)            clock and reset
//   start, max_cycles                      begin a sequence / run-cycle limit
//   load_valid/ready/data/last             program word stream
//   imem_we/addr/wdata                     instruction-memory write port
//   core_rst                               active-high core reset
//   mon_we/addr/wdata                      snooped core data stores
//   busy, done, pass, timeout, overflow    status
//   result, cycle_count, words_loaded      status values
module riscv_run_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEF_TIMEOUT = 175,
  parameter int unsigned RST_CYCLES  = 2,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h0000_0FFC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [XLEN-1:0]   load_data,
  input  logic              load_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              core_rst,
  input  logic              mon_we,
  input  logic [XLEN-1:0]   mon_addr,
  input  logic [XLEN-1:0]   mon_wdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              overflow,
  output logic [XLEN-1:0]   result,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned WL_W   = ADDR_W + 1;
  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]   limit;
  logic               go;
  logic               xfer;
  logic               ovf_hit;
  logic               tohost_hit;
  logic               wd_hit;

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    state_nxt  = state;
    go         = 1'b0;
    xfer       = 1'b0;
    ovf_hit    = 1'b0;
    tohost_hit = 1'b0;
    wd_hit     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          go        = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_valid && load_ready) begin
          xfer = 1'b1;
          if (load_last) begin
            state_nxt = S_HOLD;
          end else if (words_loaded == WL_W'(IMEM_DEPTH - 1)) begin
            // This word fills the memory and no end marker came with it.
            ovf_hit   = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        // A completion store beats watchdog expiry in the same cycle.
        if (mon_we && (mon_addr == TOHOST_ADDR)) begin
          tohost_hit = 1'b1;
          state_nxt  = S_DONE;
        end else if (cycle_count == limit) begin
          wd_hit    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      limit        <= '0;
      load_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
      result       <= '0;
      cycle_count  <= '0;
      words_loaded <= '0;
    end else begin
      state      <= state_nxt;
      load_ready <= (state_nxt == S_LOAD);
      busy       <= (state_nxt == S_LOAD) || (state_nxt == S_HOLD) || (state_nxt == S_RUN);
      core_rst   <= (state_nxt != S_RUN);
      imem_we    <= xfer;
      hold_cnt   <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;

      if (go) begin
        done         <= 1'b0;
        pass         <= 1'b0;
        timeout      <= 1'b0;
        overflow     <= 1'b0;
        result       <= '0;
        cycle_count  <= '0;
        words_loaded <= '0;
        limit        <= (max_cycles == '0) ? CNT_W'(DEF_TIMEOUT) : max_cycles;
      end

      if (xfer) begin
        imem_addr    <= words_loaded[ADDR_W-1:0];
        imem_wdata   <= load_data;
        words_loaded <= words_loaded + 1'b1;
      end

      if (ovf_hit) begin
        overflow <= 1'b1;
        done     <= 1'b1;
        pass     <= 1'b0;
      end

      // Count reads 1 in the first RUN cycle and saturates at all-ones.
      if (state_nxt == S_RUN) begin
        if (state != S_RUN)           cycle_count <= CNT_W'(1);
        else if (cycle_count != '1)   cycle_count <= cycle_count + 1'b1;
      end

      if (tohost_hit) begin
        result <= mon_wdata;
        pass   <= (mon_wdata == XLEN'(1));
        done   <= 1'b1;
      end

      if (wd_hit) begin
        timeout <= 1'b1;
        done    <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Self-checking bench for riscv_run_ctrl with a small instruction memory
// (4 words) so the full-memory and overflow boundaries are reachable.
module tb_riscv_run_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEF_TO = 175;
  localparam int unsigned RSTC   = 2;
  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  max_cycles;
  logic              load_valid;
  logic              load_ready;
  logic [XLEN-1:0]   load_data;
  logic              load_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_wdata;
  logic              core_rst;
  logic              mon_we;
  logic [XLEN-1:0]   mon_addr;
  logic [XLEN-1:0]   mon_wdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic              overflow;
  logic [XLEN-1:0]   result;
  logic [CNT_W-1:0]  cycle_count;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  logic [31:0] prog [5];

  riscv_run_ctrl #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .IMEM_DEPTH(DEPTH), .CNT_W(CNT_W),
    .DEF_TIMEOUT(DEF_TO), .RST_CYCLES(RSTC), .TOHOST_ADDR(TOHOST)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .max_cycles(max_cycles),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .mon_we(mon_we),
    .mon_addr(mon_addr), .mon_wdata(mon_wdata), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .overflow(overflow), .result(result),
    .cycle_count(cycle_count), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_core_rst"}, core_rst, 1);
    chk({tag, "_ready"}, load_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_cycles"}, cycle_count, 0);
    chk({tag, "_words"}, words_loaded, 0);
  endtask

  // Pulse start from IDLE/DONE; max_cycles is scrambled afterwards to prove it was latched.
  task automatic start_seq(input logic [CNT_W-1:0] mc);
    start = 1'b1;
    max_cycles = mc;
    step();
    start = 1'b0;
    max_cycles = CNT_W'($urandom);
    chk("st_busy", busy, 1);
    chk("st_ready", load_ready, 1);
    chk("st_done", done, 0);
    chk("st_pass", pass, 0);
    chk("st_timeout", timeout, 0);
    chk("st_overflow", overflow, 0);
    chk("st_result", result, 0);
    chk("st_cycles", cycle_count, 0);
    chk("st_words", words_loaded, 0);
    chk("st_core_rst", core_rst, 1);
  endtask

  // Stream n words with random gaps; model accepts every offered word until the
  // end marker or until the memory is full.
  task automatic load(input int n, input bit with_last);
    int   acc = 0;
    bit   mready = 1'b1;
    bit   pend = 1'b0;
    int   paddr = 0;
    logic [31:0] pdata = '0;
    for (int c = 0; c < 400; c++) begin
      chk("ld_ready", load_ready, mready);
      chk("ld_we", imem_we, pend);
      chk("ld_words", words_loaded, acc);
      chk("ld_core_rst", core_rst, 1);
      if (pend) begin
        chk("ld_addr", imem_addr, paddr);
        chk("ld_data", imem_wdata, pdata);
      end
      if (!mready) break;
      if (acc < n && $urandom_range(0, 2) != 0) begin
        load_valid = 1'b1;
        load_data  = prog[acc];
        load_last  = with_last && (acc == n - 1);
        pend  = 1'b1;
        paddr = acc;
        pdata = prog[acc];
        acc++;
        if (load_last || acc == DEPTH) mready = 1'b0;
      end else begin
        load_valid = 1'b0;
        load_data  = $urandom;
        load_last  = 1'($urandom_range(0, 1));
        pend = 1'b0;
      end
      start = 1'($urandom_range(0, 1));
      max_cycles = CNT_W'($urandom);
      step();
    end
    chk("ld_finished", mready, 0);
    load_valid = 1'b0;
    load_last  = 1'b0;
    start      = 1'b0;
  endtask

  // core_rst stays high for RSTC cycles after the last word, then drops.
  task automatic hold_check();
    for (int i = 0; i < RSTC; i++) begin
      chk("hold_core_rst", core_rst, 1);
      chk("hold_busy", busy, 1);
      step();
    end
  endtask

  // Run phase: tohost store of sdata at RUN cycle scyc (0 = none), effective limit lim.
  task automatic run(input int lim, input int scyc, input logic [31:0] sdata, input int abort_at);
    bit hit = (scyc != 0) && (scyc <= lim);
    int last = hit ? scyc : lim;
    for (int k = 1; k <= last; k++) begin
      chk("run_cycles", cycle_count, k);
      chk("run_core_rst", core_rst, 0);
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      if (k == abort_at) begin
        rst = 1'b0;
        mon_we = 1'b0;
        step();
        rst = 1'b1;
        chk_reset("abort");
        return;
      end
      if (k == scyc) begin
        mon_we = 1'b1; mon_addr = TOHOST; mon_wdata = sdata;
      end else begin
        case ($urandom_range(0, 2))
          0: begin
            mon_we = 1'b1; mon_addr = $urandom;
            if (mon_addr == TOHOST) mon_addr = '0;
            mon_wdata = 32'd1;
          end
          1: begin mon_we = 1'b0; mon_addr = TOHOST; mon_wdata = 32'd1; end
          default: begin mon_we = 1'b0; mon_addr = $urandom; mon_wdata = $urandom; end
        endcase
      end
      start = 1'($urandom_range(0, 1));
      max_cycles = CNT_W'($urandom);
      step();
    end
    mon_we = 1'b0;
    start  = 1'b0;
    chk("end_done", done, 1);
    chk("end_pass", pass, hit && (sdata == 32'd1));
    chk("end_timeout", timeout, !hit);
    chk("end_result", result, hit ? sdata : 32'd0);
    chk("end_cycles", cycle_count, last);
    chk("end_core_rst", core_rst, 1);
    chk("end_busy", busy, 0);
    chk("end_ready", load_ready, 0);
    chk("end_overflow", overflow, 0);
    step();
    step();
    chk("held_done", done, 1);
    chk("held_result", result, hit ? sdata : 32'd0);
    chk("held_cycles", cycle_count, last);
  endtask

  task automatic spec_prog();
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_8133;
    prog[2] = 32'h0000_0013;
    prog[3] = 32'hFE00_0EE3;
    prog[4] = $urandom;
  endtask

  task automatic rand_prog();
    for (int i = 0; i < 5; i++) prog[i] = $urandom;
  endtask

  initial begin
    // Reset asserted with start and other inputs active.
    rst = 1'b0; start = 1'b1; max_cycles = 16'd5;
    load_valid = 1'b1; load_data = '1; load_last = 1'b1;
    mon_we = 1'b1; mon_addr = TOHOST; mon_wdata = 32'd1;
    step();
    step();
    chk_reset("reset");
    rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_last = 1'b0; mon_we = 1'b0;
    step();
    chk_reset("idle");

    // Program load at full memory depth with end marker, then pass at cycle 40.
    spec_prog();
    start_seq(16'd0);
    load(4, 1'b1);
    chk("full_words", words_loaded, 4);
    chk("full_overflow", overflow, 0);
    hold_check();
    run(DEF_TO, 40, 32'd1, 0);

    // Watchdog expiry with no store.
    rand_prog();
    start_seq(16'd10);
    load(2, 1'b1);
    hold_check();
    run(10, 0, 32'd0, 0);

    // Tohost store in the expiry cycle wins.
    rand_prog();
    start_seq(16'd10);
    load(3, 1'b1);
    hold_check();
    run(10, 10, 32'd7, 0);

    // Overflow: five words, no end marker.
    rand_prog();
    start_seq(16'd0);
    load(5, 1'b0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_done", done, 1);
    chk("ovf_pass", pass, 0);
    chk("ovf_timeout", timeout, 0);
    chk("ovf_busy", busy, 0);
    chk("ovf_core_rst", core_rst, 1);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = prog[4]; load_last = 1'b1;
      step();
      chk("ovf_we", imem_we, 0);
      chk("ovf_words", words_loaded, 4);
      chk("ovf_ready", load_ready, 0);
      chk("ovf_hold", overflow, 1);
    end
    load_valid = 1'b0; load_last = 1'b0;

    // Abort mid-run, then restart and pass.
    rand_prog();
    start_seq(16'd100);
    load(4, 1'b1);
    hold_check();
    run(100, 0, 32'd0, 20);
    step();
    chk_reset("post_abort");
    spec_prog();
    start_seq(16'd50);
    load(4, 1'b1);
    hold_check();
    run(50, 33, 32'd1, 0);

    // Randomized sequences.
    for (int t = 0; t < 8; t++) begin
      int n, mc, lim, sc;
      logic [31:0] sd;
      rand_prog();
      n   = $urandom_range(1, DEPTH);
      mc  = (t == 0) ? 0 : $urandom_range(0, 60);
      lim = (mc == 0) ? DEF_TO : mc;
      sc  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, lim + 5);
      sd  = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
      start_seq(CNT_W'(mc));
      load(n, 1'b1);
      hold_check();
      run(lim, sc, sd, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
